// File: rtl/spi_rx_sequencer.sv
// SPI peripheral receive sequencer: synchronise, frame, length-check, queue words.
// Optional parity bit per frame when SPI_PARITY_EN is defined.
module spi_rx_sequencer #(
    parameter int WORD_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sck,
    input  logic              cs,
    input  logic              sdi,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              busy,
    output logic              overflow,
    output logic              frame_err
);

`ifdef SPI_PARITY_EN
    localparam int FRAME_BITS = WORD_W + 1;
`else
    localparam int FRAME_BITS = WORD_W;
`endif
    localparam int CNT_W  = $clog2(FRAME_BITS + 2);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_BITS + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t                r_state;
    logic                  r_cs_m, r_cs_s;
    logic                  r_sck_m, r_sck_s, r_sck_q;
    logic                  r_sdi_m, r_sdi_s;
    logic [FRAME_BITS-1:0] r_shreg;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic                  r_overflow, r_frame_err;
    logic [WORD_W-1:0]     r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_rd_ptr, r_wr_ptr;
    logic [FCNT_W-1:0]     r_fcnt;

    logic              w_sck_rise;
    logic              w_len_ok, w_par_ok, w_frame_ok;
    logic              w_full, w_pop, w_push;
    logic [WORD_W-1:0] w_payload;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cs_m  <= 1'b0;
            r_cs_s  <= 1'b0;
            r_sck_m <= 1'b0;
            r_sck_s <= 1'b0;
            r_sck_q <= 1'b0;
            r_sdi_m <= 1'b0;
            r_sdi_s <= 1'b0;
        end else begin
            r_cs_m  <= cs;
            r_cs_s  <= r_cs_m;
            r_sck_m <= sck;
            r_sck_s <= r_sck_m;
            r_sck_q <= r_sck_s;
            r_sdi_m <= sdi;
            r_sdi_s <= r_sdi_m;
        end
    end

    assign w_sck_rise = r_sck_s & ~r_sck_q;
    assign w_len_ok   = (r_bit_cnt == CNT_W'(FRAME_BITS));

`ifdef SPI_PARITY_EN
    // Even parity: payload bits plus parity bit must XOR to zero
    assign w_par_ok  = ~(^r_shreg);
    assign w_payload = r_shreg[FRAME_BITS-1:1];
`else
    assign w_par_ok  = 1'b1;
    assign w_payload = r_shreg;
`endif

    assign w_frame_ok = w_len_ok & w_par_ok;
    assign w_full     = (r_fcnt == FCNT_W'(FIFO_DEPTH));
    assign w_pop      = rx_ready & (r_fcnt != '0);
    assign w_push     = (r_state == S_DONE) & w_frame_ok & (~w_full | w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (r_cs_s) begin
                        r_state   <= S_SHIFT;
                        r_shreg   <= '0;
                        r_bit_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    if (w_sck_rise) begin
                        r_shreg <= {r_shreg[FRAME_BITS-2:0], r_sdi_s};
                        if (r_bit_cnt != CNT_MAX)
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                    if (!r_cs_s)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    if (!w_frame_ok)
                        r_frame_err <= 1'b1;
                    else if (w_full && !w_pop)
                        r_overflow <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                r_mem[i] <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_fcnt   <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_payload;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)
                r_fcnt <= r_fcnt + FCNT_W'(1);
            else if (w_pop && !w_push)
                r_fcnt <= r_fcnt - FCNT_W'(1);
        end
    end

    assign rx_data   = r_mem[r_rd_ptr];
    assign rx_valid  = (r_fcnt != '0);
    assign busy      = (r_state != S_IDLE);
    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;

endmodule
